// File: rtl/cnn_layer_sequencer_pkg.sv
// Shared types and default sizes for the CNN layer sequencer.
// The ERR state exists only when SEQ_TIMEOUT_EN is defined.
package cnn_seq_pkg;

    localparam int DEF_NUM_CLASSES = 10;
    localparam int DEF_PROB_W      = 113;
    localparam int DEF_IDX_W       = 4;
    localparam int DEF_TIMEOUT_CYC = 4096;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_RELU,
        S_POOL,
        S_FC,
        S_ARGMAX,
        S_DONE
`ifdef SEQ_TIMEOUT_EN
        , S_ERR
`endif
    } seq_state_t;

endpackage

// File: rtl/cnn_layer_sequencer_if.sv
// Bundle between the sequencer (master) and the layers, score mux and
// result consumer (slave). Also carries the FSM state for observation.
interface cnn_seq_if
    import cnn_seq_pkg::*;
#(
    parameter int PROB_W = DEF_PROB_W,
    parameter int IDX_W  = DEF_IDX_W
);
    // Handshake: start and each *_done are plain levels sampled on posedge;
    // an enable stays high until its done is seen, and result is valid only
    // in the single cycle result_valid is high.
    logic                     start;
    logic                     busy;
    logic                     conv_enable;
    logic                     relu_enable;
    logic                     pool_enable;
    logic                     fc_enable;
    logic                     conv_done;
    logic                     relu_done;
    logic                     pool_done;
    logic                     fc_done;
    logic [IDX_W-1:0]         prob_idx;
    logic signed [PROB_W-1:0] prob_data;
    logic [IDX_W-1:0]         result;
    logic                     result_valid;
    logic                     error;
    seq_state_t               state;

    modport master (
        input  start, conv_done, relu_done, pool_done, fc_done, prob_data,
        output busy, conv_enable, relu_enable, pool_enable, fc_enable,
               prob_idx, result, result_valid, error, state
    );

    modport slave (
        output start, conv_done, relu_done, pool_done, fc_done, prob_data,
        input  busy, conv_enable, relu_enable, pool_enable, fc_enable,
               prob_idx, result, result_valid, error, state
    );

endinterface

// File: rtl/cnn_layer_sequencer_argmax.sv
// Serial signed max tracker: one score per valid cycle, lowest index wins ties.
// arg_next exposes the post-update index so the final score can be captured same-edge.
module argmax_stream #(
    parameter int PROB_W = 113,
    parameter int IDX_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     valid,
    input  logic [IDX_W-1:0]         idx,
    input  logic signed [PROB_W-1:0] data,
    output logic [IDX_W-1:0]         arg,
    output logic [IDX_W-1:0]         arg_next,
    output logic signed [PROB_W-1:0] max
);

    logic signed [PROB_W-1:0] max_next;

    always_comb begin
        arg_next = arg;
        max_next = max;
        if (valid) begin
            if (clear || (data > max)) begin
                arg_next = idx;
                max_next = data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arg <= '0;
            max <= '0;
        end else begin
            arg <= arg_next;
            max <= max_next;
        end
    end

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Control FSM stepping conv -> relu -> pool -> fc -> argmax for one image.
// Optional per-stage watchdog and ERR state: define SEQ_TIMEOUT_EN.
module cnn_layer_sequencer
    import cnn_seq_pkg::*;
#(
    parameter int NUM_CLASSES = DEF_NUM_CLASSES,
    parameter int PROB_W      = DEF_PROB_W,
    parameter int IDX_W       = DEF_IDX_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic     clk,
    input  logic     rst,
    cnn_seq_if.master bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    seq_state_t               state;
    seq_state_t               state_next;
    logic [IDX_W-1:0]         idx;
    logic                     in_stage;
    logic                     stage_done;
    logic [IDX_W-1:0]         arg_next;
    logic [IDX_W-1:0]         unused_arg;
    logic signed [PROB_W-1:0] unused_max;

`ifdef SEQ_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CNT_W-1:0] stage_cnt;
    logic             timeout;
    logic             error_q;

    assign timeout = (stage_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next       = state;
        in_stage         = 1'b0;
        stage_done       = 1'b0;
        bus.busy         = (state != S_IDLE);
        bus.conv_enable  = 1'b0;
        bus.relu_enable  = 1'b0;
        bus.pool_enable  = 1'b0;
        bus.fc_enable    = 1'b0;
        bus.prob_idx     = '0;
        bus.result_valid = 1'b0;
        bus.state        = state;
        case (state)
            S_IDLE: begin
                if (bus.start) state_next = S_CONV;
            end
            S_CONV: begin
                in_stage        = 1'b1;
                bus.conv_enable = 1'b1;
                stage_done      = bus.conv_done;
                if (stage_done) state_next = S_RELU;
            end
            S_RELU: begin
                in_stage        = 1'b1;
                bus.relu_enable = 1'b1;
                stage_done      = bus.relu_done;
                if (stage_done) state_next = S_POOL;
            end
            S_POOL: begin
                in_stage        = 1'b1;
                bus.pool_enable = 1'b1;
                stage_done      = bus.pool_done;
                if (stage_done) state_next = S_FC;
            end
            S_FC: begin
                in_stage      = 1'b1;
                bus.fc_enable = 1'b1;
                stage_done    = bus.fc_done;
                if (stage_done) state_next = S_ARGMAX;
            end
            S_ARGMAX: begin
                bus.prob_idx = idx;
                if (idx == LAST_IDX) state_next = S_DONE;
            end
            S_DONE: begin
                bus.result_valid = 1'b1;
                state_next       = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
`ifdef SEQ_TIMEOUT_EN
        // A done arriving on the last allowed cycle still wins over the watchdog.
        if (in_stage && !stage_done && timeout) state_next = S_ERR;
`endif
    end

    // Score index counter: runs only in ARGMAX, parked at 0 otherwise.
    always_ff @(posedge clk) begin
        if (rst)                                     idx <= '0;
        else if (state == S_ARGMAX && idx != LAST_IDX) idx <= idx + IDX_W'(1);
        else                                         idx <= '0;
    end

    argmax_stream #(
        .PROB_W (PROB_W),
        .IDX_W  (IDX_W)
    ) u_argmax (
        .clk      (clk),
        .rst      (rst),
        .clear    ((state == S_ARGMAX) && (idx == '0)),
        .valid    (state == S_ARGMAX),
        .idx      (idx),
        .data     (bus.prob_data),
        .arg      (unused_arg),
        .arg_next (arg_next),
        .max      (unused_max)
    );

    // Captured on the ARGMAX->DONE edge so result lines up with result_valid.
    always_ff @(posedge clk) begin
        if (rst)                                        bus.result <= '0;
        else if (state == S_ARGMAX && idx == LAST_IDX)  bus.result <= arg_next;
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst || state_next != state) stage_cnt <= '0;
        else                            stage_cnt <= stage_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)                              error_q <= 1'b0;
        else if (state == S_IDLE && bus.start) error_q <= 1'b0;
        else if (state_next == S_ERR)         error_q <= 1'b1;
    end

    assign bus.error = error_q;
`else
    assign bus.error = 1'b0;
`endif

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed-plus-random bench for cnn_layer_sequencer; layers and score mux are
// modelled here, expected winners come from a plain first-maximum scan.
module tb_cnn_layer_sequencer;
    import cnn_seq_pkg::*;

    localparam int NC = 10;
    localparam int PW = 113;
    localparam int IW = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   hold_start = 1'b0;
    int   lat [4];
    logic signed [PW-1:0] scores [NC];

    cnn_seq_if #(.PROB_W(PW), .IDX_W(IW)) bus ();

    cnn_layer_sequencer #(
        .NUM_CLASSES (NC),
        .PROB_W      (PW),
        .IDX_W       (IW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // External score mux: combinational in the same cycle as prob_idx.
    always_comb begin
        if (int'(bus.prob_idx) < NC) bus.prob_data = scores[bus.prob_idx];
        else                         bus.prob_data = '0;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_argmax();
        int best = 0;
        for (int i = 1; i < NC; i++)
            if (scores[i] > scores[best]) best = i;
        return best;
    endfunction

    function automatic logic [3:0] enables();
        return {bus.fc_enable, bus.pool_enable, bus.relu_enable, bus.conv_enable};
    endfunction

    task automatic set_done(input int s, input logic v);
        case (s)
            0: bus.conv_done = v;
            1: bus.relu_done = v;
            2: bus.pool_done = v;
            default: bus.fc_done = v;
        endcase
    endtask

    task automatic clear_inputs();
        bus.conv_done = 1'b0;
        bus.relu_done = 1'b0;
        bus.pool_done = 1'b0;
        bus.fc_done   = 1'b0;
        bus.start     = hold_start;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = hold_start;
    endtask

    // Holds the layer busy for n cycles, raising done in the last one.
    task automatic run_stage(input int s, input int n, input bit spur);
        for (int i = 0; i < n; i++) begin
            check($sformatf("enable_s%0d_c%0d", s, i), enables(), 4'b0001 << s);
            check("busy_stage", bus.busy, 1'b1);
            if (spur && s == 0 && i < n - 1) bus.pool_done = 1'b1;
            if (spur && s == 2 && i == 0)    bus.start = 1'b1;
            if (i == n - 1) set_done(s, 1'b1);
            step();
            clear_inputs();
        end
    endtask

    task automatic argmax_phase(input int exp);
        for (int i = 0; i < NC; i++) begin
            check($sformatf("prob_idx_%0d", i), bus.prob_idx, i);
            check("enables_argmax", enables(), 4'b0000);
            check("rv_argmax", bus.result_valid, 1'b0);
            step();
        end
        check("result_valid_done", bus.result_valid, 1'b1);
        check("result_done", bus.result, exp);
        check("busy_done", bus.busy, 1'b1);
        step();
        check("result_valid_after", bus.result_valid, 1'b0);
        check("busy_after", bus.busy, 1'b0);
        check("result_hold", bus.result, exp);
        check("prob_idx_idle", bus.prob_idx, 0);
    endtask

    task automatic full_run(input bit spur);
        int exp;
        exp = ref_argmax();
        do_start();
        for (int s = 0; s < 4; s++) run_stage(s, lat[s], spur);
        argmax_phase(exp);
    endtask

    initial begin
        logic [127:0] wide;
        int           v;
        bus.start = 1'b0;
        clear_inputs();
        for (int i = 0; i < NC; i++) scores[i] = '0;
        for (int s = 0; s < 4; s++) lat[s] = 5;

        // Reset values
        repeat (3) step();
        check("rst_enables", enables(), 4'b0000);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_result", bus.result, 0);
        check("rst_rv", bus.result_valid, 1'b0);
        check("rst_error", bus.error, 1'b0);
        check("rst_prob_idx", bus.prob_idx, 0);
        check("rst_state", bus.state, S_IDLE);
        rst = 1'b0;
        step();

        // Nominal: scores {3,-7,12,12,0...}, every layer takes 5 cycles
        scores[0] = PW'(3);
        scores[1] = PW'(-7);
        scores[2] = PW'(12);
        scores[3] = PW'(12);
        check("model_nominal", ref_argmax(), 2);
        full_run(1'b0);

        // All negative except idx 9
        for (int i = 0; i < NC; i++) scores[i] = PW'(-100);
        scores[9] = PW'(-1);
        full_run(1'b0);

        // All equal: lowest index wins
        v = -int'($urandom_range(1, 1000));
        for (int i = 0; i < NC; i++) scores[i] = PW'(v);
        full_run(1'b0);

        // Spurious start in POOL and pool_done in CONV; no queued inference
        for (int i = 0; i < NC; i++) scores[i] = PW'(int'($urandom_range(0, 40)) - 20);
        full_run(1'b1);
        step();
        check("no_queued_start", bus.busy, 1'b0);

        // Second start after completion runs a full new inference, random latencies
        for (int s = 0; s < 4; s++) lat[s] = $urandom_range(1, 7);
        for (int i = 0; i < NC; i++) begin
            wide = {$urandom(), $urandom(), $urandom(), $urandom()};
            scores[i] = wide[PW-1:0];
        end
        full_run(1'b0);

        // Random narrow-range scores to provoke ties
        repeat (3) begin
            for (int s = 0; s < 4; s++) lat[s] = $urandom_range(1, 4);
            for (int i = 0; i < NC; i++) scores[i] = PW'(int'($urandom_range(0, 6)) - 3);
            full_run(1'b0);
        end

        // Leave a known nonzero result, then reset during FC cycle 3
        for (int i = 0; i < NC; i++) scores[i] = '0;
        scores[7] = PW'(5);
        for (int s = 0; s < 4; s++) lat[s] = 2;
        full_run(1'b0);
        check("pre_reset_result", bus.result, 7);
        do_start();
        for (int s = 0; s < 3; s++) run_stage(s, 2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("fc_enable_pre_rst", enables(), 4'b1000);
            if (i == 2) rst = 1'b1;
            step();
        end
        rst = 1'b0;
        check("midrst_enables", enables(), 4'b0000);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_result", bus.result, 0);
        check("midrst_state", bus.state, S_IDLE);
        check("midrst_prob_idx", bus.prob_idx, 0);
        step();

`ifdef SEQ_TIMEOUT_EN
        // relu_done never comes: enable high for TO cycles, then ERR, then IDLE
        do_start();
        run_stage(0, 3, 1'b0);
        for (int i = 0; i < TO; i++) begin
            check("relu_wait", enables(), 4'b0010);
            check("err_low_wait", bus.error, 1'b0);
            step();
        end
        check("err_enables", enables(), 4'b0000);
        check("err_flag", bus.error, 1'b1);
        check("err_busy", bus.busy, 1'b1);
        check("err_result_kept", bus.result, 0);
        step();
        check("err_idle_busy", bus.busy, 1'b0);
        check("err_sticky", bus.error, 1'b1);
        step();
        check("err_sticky2", bus.error, 1'b1);
        scores[4] = PW'(50);
        do_start();
        check("err_cleared", bus.error, 1'b0);
        for (int s = 0; s < 4; s++) run_stage(s, 2, 1'b0);
        argmax_phase(4);
`endif

        // Back-to-back: start held high, restart only via IDLE
        for (int i = 0; i < NC; i++) scores[i] = PW'(int'($urandom_range(0, 100)));
        hold_start = 1'b1;
        bus.start = 1'b1;
        step();
        for (int s = 0; s < 4; s++) run_stage(s, 3, 1'b0);
        argmax_phase(ref_argmax());
        for (int i = 0; i < NC; i++) scores[i] = PW'(int'($urandom_range(0, 100)));
        step();
        hold_start = 1'b0;
        bus.start = 1'b0;
        for (int s = 0; s < 4; s++) run_stage(s, 3, 1'b0);
        argmax_phase(ref_argmax());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
